// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity type codes and a
// small majority-vote helper. The transmitter imports the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // 2-of-3 majority of the samples taken around the bit centre.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: counts clk cycles within a bit,
// captures three samples around the bit centre and strobes the voted value.
// The strobe at M+2 must land inside the bit, so OVERSAMPLE needs to be >= 6
// for the vote to complete before the period wraps.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_s,          // synchronised serial line
    input  logic active,        // counter runs while the receiver is framing
    output logic sample_valid,  // voted bit is ready this cycle
    output logic sample_bit,    // majority of the three centre samples
    output logic bit_end        // last cycle of the current bit period
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);

    logic [CW-1:0] edge_cnt;
    logic [2:0]    votes;

    assign bit_end      = (edge_cnt == CW'(OVERSAMPLE - 1));
    assign sample_valid = (edge_cnt == CW'(M + 2));
    assign sample_bit   = maj3(votes[0], votes[1], votes[2]);

    // Count cycles within a bit period; parked at 0 whenever the receiver idles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt <= '0;
        end else if (!active || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // Capture the line at M-1, M and M+1 so the vote is ready at M+2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            votes <= '0;
        end else begin
            if (edge_cnt == CW'(M - 1)) votes[0] <= rx_s;
            if (edge_cnt == CW'(M))     votes[1] <= rx_s;
            if (edge_cnt == CW'(M + 1)) votes[2] <= rx_s;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: synchronises rx_in, detects the start bit, deserialises
// FRAME_WIDTH data bits LSB-first, checks optional parity and the stop bit,
// and presents the word with single-cycle status pulses.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int FRAME_WIDTH = 8,
    parameter int OVERSAMPLE  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    input  logic                   par_en,
    input  logic                   par_typ,
    output logic [FRAME_WIDTH-1:0] p_data,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   busy
);

    localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

    uart_state_e            state;
    uart_state_e            next_state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_s_d;
    logic                   start_edge;
    logic                   active;
    logic                   sample_valid;
    logic                   sample_bit;
    logic                   bit_end;
    logic                   last_bit;
    logic                   frame_eval;
    logic                   exp_par;
    logic [BW-1:0]          bit_cnt;
    logic [FRAME_WIDTH-1:0] shift;
    logic                   par_en_l;
    logic                   par_typ_l;
    logic                   par_bad;

    // Only a 1->0 transition starts a frame, so a line stuck low never retriggers.
    assign start_edge = rx_s_d & ~rx_s;
    assign last_bit   = (bit_cnt == BW'(FRAME_WIDTH - 1));
    assign active     = (next_state != IDLE);
    assign busy       = (state != IDLE);

    // Two-flop synchroniser plus the previous-value flop for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .rx_s         (rx_s),
        .active       (active),
        .sample_valid (sample_valid),
        .sample_bit   (sample_bit),
        .bit_end      (bit_end)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the frame is judged mid-stop so back-to-back frames fit.
    // NOTE: every signal driven here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        next_state = state;
        frame_eval = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) next_state = START;
            end
            START: begin
                if (sample_valid && sample_bit) next_state = IDLE;
                else if (bit_end)               next_state = DATA;
            end
            DATA: begin
                if (bit_end && last_bit) next_state = par_en_l ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                if (sample_valid) begin
                    frame_eval = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Parity bit the sender should have produced for the collected data.
    always_comb begin
        exp_par = ^shift;
        case (par_typ_l)
            PAR_EVEN: exp_par = ^shift;
            PAR_ODD:  exp_par = ~^shift;
            default:  exp_par = ^shift;
        endcase
    end

    // Per-frame datapath: latched frame options, bit counter, shifter, parity result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            par_bad   <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        par_en_l  <= par_en;
                        par_typ_l <= par_typ;
                        par_bad   <= 1'b0;
                        bit_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (sample_valid) shift <= {sample_bit, shift[FRAME_WIDTH-1:1]};
                    if (bit_end)      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                end
                PARITY: begin
                    if (sample_valid) par_bad <= (exp_par != sample_bit);
                end
                default: ;
            endcase
        end
    end

    // Registered frame outcome: any error drops the word and keeps p_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (frame_eval) begin
                if (sample_bit && !par_bad) begin
                    data_valid <= 1'b1;
                    p_data     <= shift;
                end
                if (!sample_bit) stp_err <= 1'b1;
                if (par_bad)     par_err <= 1'b1;
            end
        end
    end

endmodule
